tdm_mux_4to1: RTL and testbench
===============================

TDM_MUX_4TO1 -- requirements
Module: tdm_mux_4to1

Interface
REQ-001 SLOT_LEN, 1, clock cycles per output slot; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; the block has one clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  request to transmit frames; sampled only at frame boundaries.
REQ-005 I  input  4  channel data; bit k is channel k.
REQ-006 mask  input  4  channel enable; bit k=1 includes channel k in the frame.
REQ-007 d_out  output  1  serial data of the current slot (feeds the 1-to-4 demux D input).
REQ-008 sel  output  2  channel index of the current slot; sel[1]=S1, sel[0]=S0.
REQ-009 valid  output  1  high while d_out/sel carry a slot.
REQ-010 frame_start  output  1  high during the first slot of each frame.
REQ-011 frame_cnt  output  8  count of completed frames; wraps modulo 256.

Function
REQ-012 The FSM SHALL have two states: IDLE and SEND.
REQ-013 Frame start: at an edge in IDLE with en=1 and mask!=0, the block SHALL capture snap<=I and msk<=mask, and enter SEND.
  - It SHALL set sel to the lowest set bit of mask, d_out=I[sel], valid=1 and frame_start=1.
  - Latency from en to the first valid slot is 1 cycle.
REQ-014 In IDLE with en=0 or mask==0, the block SHALL hold IDLE with valid=0, d_out=0, sel=0 and frame_start=0.
REQ-015 Each slot SHALL hold d_out, sel and valid stable for exactly SLOT_LEN cycles, timed by a slot counter that runs 0..SLOT_LEN-1.
REQ-016 At the end of a slot, if msk has a set bit above sel, the block SHALL advance sel to the next higher set bit, set d_out=snap[sel] and clear frame_start.
  - Masked channels are skipped and take zero cycles.
REQ-017 At the end of the last slot, the block SHALL increment frame_cnt by 1 (255->0).
  - If en=1 and mask!=0 at that edge, it SHALL start a new frame on the same edge per REQ-013, with no idle gap.
  - Otherwise it SHALL return to IDLE with outputs as in REQ-014.
REQ-018 Changes on I and mask during SEND SHALL NOT affect the frame in progress; d_out always comes from snap.
REQ-019 Deasserting en mid-frame SHALL NOT truncate the frame; the frame completes and then REQ-017 applies.
REQ-020 sel SHALL increase strictly within a frame and SHALL never name a channel whose msk bit is 0.
REQ-021 Outputs SHALL be registered, with no combinational path from the inputs to the outputs.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, independent of clk, force the following, and hold them while rst_n=0:
  - state=IDLE
  - d_out=0, sel=0, valid=0, frame_start=0, frame_cnt=0
  - snap=0, msk=0, slot counter=0
REQ-023 Reset asserted mid-frame SHALL abort the frame without incrementing frame_cnt.
REQ-024 After rst_n deasserts, the first frame SHALL start on the first edge meeting REQ-013.

Verification
REQ-025 SLOT_LEN=1, mask=4'b1111, I=4'b1010, en pulsed for 1 cycle -> over 4 cycles:
  - sel=0,1,2,3 and d_out=0,1,0,1
  - frame_start=1 only in the first cycle
  - then valid=0 and frame_cnt=1
REQ-026 SLOT_LEN=1, mask=4'b0101, I=4'b1111, en held high -> sel=0,2,0,2,... with no gap; frame_start on every sel=0 slot; frame_cnt +1 every 2 cycles; wraps 255->0 after 256 frames.
REQ-027 mask=4'b0000 with en=1 for 10 cycles -> valid=0 throughout and frame_cnt unchanged.
REQ-028 SLOT_LEN=3, mask=4'b1001, I=4'b1000, en pulse -> sel=0 (d_out=0) for 3 cycles, then sel=3 (d_out=1) for 3 cycles; valid high for 6 cycles.
REQ-029 mask=4'b1111, I=4'b0000 at start, I driven to 4'b1111 in cycle 2 -> d_out=0 for all 4 slots; the next frame transmits 1,1,1,1.
REQ-030 rst_n driven low between clock edges in the third slot -> all outputs 0 immediately and frame_cnt=0; after release with en=1, a new frame starts at sel=lowest mask bit.
REQ-031 Loopback: d_out, sel[1], sel[0] drive the 1-to-4 demux D, S1, S0 -> when valid=1, demux output Y[sel] equals I[sel] of the frame snapshot.

Source files
------------

// File: rtl/tdm_mux_4to1.sv
// Four-channel time-division multiplexer feeding a serial 1-to-4 demux.
// A frame walks the enabled channels lowest-first; each slot lasts SLOT_LEN cycles.
module tdm_mux_4to1 #(
  parameter int unsigned SLOT_LEN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] I,
  input  logic [3:0] mask,
  output logic       d_out,
  output logic [1:0] sel,
  output logic       valid,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CH_N  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned FRM_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CH_N-1:0]    snap, snap_nxt;
  logic [CH_N-1:0]    msk, msk_nxt;
  logic [CNT_W-1:0]   slot_cnt, slot_cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               d_out_nxt;
  logic               valid_nxt;
  logic               frame_start_nxt;
  logic [FRM_W-1:0]   frame_cnt_nxt;

  logic               start_ok;
  logic               slot_end;
  logic [SEL_W-1:0]   first_sel;
  logic               has_next;
  logic [SEL_W-1:0]   next_sel;
  logic               launch;
  logic               to_idle;

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] low_bit(input logic [CH_N-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (m[k]) r = SEL_W'(k);
    end
    return r;
  endfunction

  // Next set bit strictly above s; MSB of the result flags whether one exists.
  function automatic logic [SEL_W:0] bit_above(input logic [CH_N-1:0] m,
                                               input logic [SEL_W-1:0] s);
    logic [SEL_W:0] r;
    r = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (m[k] && (k > int'(s))) r = {1'b1, SEL_W'(k)};
    end
    return r;
  endfunction

  // Frame-boundary qualifiers and channel stepping.
  always_comb begin
    logic [SEL_W:0] nb;
    nb        = bit_above(msk, sel);
    start_ok  = en && (mask != '0);
    slot_end  = (slot_cnt == CNT_W'(SLOT_LEN - 1));
    first_sel = low_bit(mask);
    has_next  = nb[SEL_W];
    next_sel  = nb[SEL_W-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    snap_nxt        = snap;
    msk_nxt         = msk;
    slot_cnt_nxt    = slot_cnt;
    sel_nxt         = sel;
    d_out_nxt       = d_out;
    valid_nxt       = valid;
    frame_start_nxt = frame_start;
    frame_cnt_nxt   = frame_cnt;
    launch          = 1'b0;
    to_idle         = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) launch  = 1'b1;
        else          to_idle = 1'b1;
      end
      SEND: begin
        if (!slot_end) begin
          slot_cnt_nxt = slot_cnt + CNT_W'(1);
        end else if (has_next) begin
          slot_cnt_nxt    = '0;
          sel_nxt         = next_sel;
          d_out_nxt       = snap[next_sel];
          frame_start_nxt = 1'b0;
        end else begin
          frame_cnt_nxt = frame_cnt + FRM_W'(1);
          if (start_ok) launch  = 1'b1;
          else          to_idle = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase

    // New frame: snapshot inputs and open the lowest enabled slot.
    if (launch) begin
      state_nxt       = SEND;
      snap_nxt        = I;
      msk_nxt         = mask;
      slot_cnt_nxt    = '0;
      sel_nxt         = first_sel;
      d_out_nxt       = I[first_sel];
      valid_nxt       = 1'b1;
      frame_start_nxt = 1'b1;
    end

    // Quiet line between frames.
    if (to_idle) begin
      state_nxt       = IDLE;
      slot_cnt_nxt    = '0;
      sel_nxt         = '0;
      d_out_nxt       = 1'b0;
      valid_nxt       = 1'b0;
      frame_start_nxt = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Snapshot, slot timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap        <= '0;
      msk         <= '0;
      slot_cnt    <= '0;
      sel         <= '0;
      d_out       <= 1'b0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      snap        <= snap_nxt;
      msk         <= msk_nxt;
      slot_cnt    <= slot_cnt_nxt;
      sel         <= sel_nxt;
      d_out       <= d_out_nxt;
      valid       <= valid_nxt;
      frame_start <= frame_start_nxt;
      frame_cnt   <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_mux_4to1.sv
// Bench for tdm_mux_4to1: one-cycle-slot instance driven from a vector table
// and scoreboard, plus a three-cycle-slot instance and a mid-frame reset.
module tb_tdm_mux_4to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n1, en1, rst_n3, en3;
  logic [3:0] i1, mask1, i3, mask3;
  logic       d1, v1, fs1, d3, v3, fs3;
  logic [1:0] sel1, sel3;
  logic [7:0] cnt1, cnt3;

  tdm_mux_4to1 #(.SLOT_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .en(en1), .I(i1), .mask(mask1),
    .d_out(d1), .sel(sel1), .valid(v1), .frame_start(fs1), .frame_cnt(cnt1)
  );

  tdm_mux_4to1 #(.SLOT_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .en(en3), .I(i3), .mask(mask3),
    .d_out(d3), .sel(sel3), .valid(v3), .frame_start(fs3), .frame_cnt(cnt3)
  );

  wire [12:0] out1 = {v1, sel1, d1, fs1, cnt1};
  wire [12:0] out3 = {v3, sel3, d3, fs3, cnt3};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [3:0] i;
    logic [3:0] mask;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];

  function automatic logic [12:0] pk(logic v, logic [1:0] s, logic d, logic f, logic [7:0] c);
    return {v, s, d, f, c};
  endfunction

  function automatic vec_t mk(logic e, logic [3:0] i, logic [3:0] m,
                              logic v, logic [1:0] s, logic d, logic f, logic [7:0] c);
    vec_t r;
    r.en = e; r.i = i; r.mask = m; r.exp = pk(v, s, d, f, c);
    return r;
  endfunction

  task automatic check(string name, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b sel=%0d d=%0b fs=%0b cnt=%0d, expected v=%0b sel=%0d d=%0b fs=%0b cnt=%0d",
               name, act[12], act[11:10], act[9], act[8], act[7:0],
               exp[12], exp[11:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Drive one cycle of stimulus on dut1, queue its expectation, compare after the edge.
  task automatic apply(string name, logic e, logic [3:0] i, logic [3:0] m, logic [12:0] exp);
    logic [12:0] x;
    logic [3:0]  y, ye;
    en1 = e; i1 = i; mask1 = m;
    sb.push_back(exp);
    @(negedge clk);
    x = sb.pop_front();
    check(name, out1, x);
    if (v1) begin
      y  = '0; y[sel1] = d1;
      ye = '0; ye[x[11:10]] = x[9];
      checks++;
      if (y !== ye) begin
        errors++;
        $display("FAIL %s_demux: got Y=%b, expected Y=%b", name, y, ye);
      end
    end
  endtask

  initial begin
    logic [12:0] exp3[8];

    rst_n1 = 1'b0; rst_n3 = 1'b0;
    en1 = 1'b0; i1 = '0; mask1 = '0;
    en3 = 1'b0; i3 = '0; mask3 = '0;
    #1;
    check("reset1", out1, 13'd0);
    check("reset3", out3, 13'd0);
    @(negedge clk);
    rst_n1 = 1'b1; rst_n3 = 1'b1;

    // Pulsed frame over all four channels.
    vecs.push_back(mk(1, 4'b1010, 4'b1111, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1111, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1111, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1111, 1, 3, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1111, 0, 0, 0, 0, 1));
    // Empty mask never starts a frame.
    for (int k = 0; k < 10; k++) vecs.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1));
    // Snapshot isolation, back-to-back frames, late en drop.
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 2, 0, 0, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 3, 0, 0, 1));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 1, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 1, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 2, 1, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 3, 1, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3));
    // Frame starting at a non-zero lowest channel.
    vecs.push_back(mk(1, 4'b0100, 4'b0110, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 4'b0100, 4'b0110, 1, 2, 1, 0, 3));
    vecs.push_back(mk(0, 4'b0100, 4'b0110, 0, 0, 0, 0, 4));

    for (int k = 0; k < vecs.size(); k++)
      apply($sformatf("vec%0d", k), vecs[k].en, vecs[k].i, vecs[k].mask, vecs[k].exp);

    // Continuous two-channel frames through a frame counter wrap.
    for (int j = 0; j < 514; j++)
      apply($sformatf("stream%0d", j), 1'b1, 4'b1111, 4'b0101,
            pk(1'b1, (j % 2 == 1) ? 2'd2 : 2'd0, 1'b1, (j % 2 == 0), 8'(4 + j / 2)));
    apply("stream_end", 1'b0, 4'b1111, 4'b0101, pk(0, 0, 0, 0, 8'(4 + 257)));

    // Asynchronous reset in the third slot.
    apply("rst_pre0", 1'b1, 4'b0110, 4'b1110, pk(1, 1, 1, 1, 5));
    apply("rst_pre1", 1'b0, 4'b0110, 4'b1110, pk(1, 2, 1, 0, 5));
    apply("rst_pre2", 1'b0, 4'b0110, 4'b1110, pk(1, 3, 0, 0, 5));
    #2 rst_n1 = 1'b0;
    #1 check("async_reset", out1, 13'd0);
    @(negedge clk);
    check("reset_hold", out1, 13'd0);
    rst_n1 = 1'b1;
    apply("rst_post0", 1'b1, 4'b0110, 4'b1110, pk(1, 1, 1, 1, 0));
    apply("rst_post1", 1'b0, 4'b0110, 4'b1110, pk(1, 2, 1, 0, 0));
    apply("rst_post2", 1'b0, 4'b0110, 4'b1110, pk(1, 3, 0, 0, 0));
    apply("rst_post3", 1'b0, 4'b0110, 4'b1110, pk(0, 0, 0, 0, 1));

    // Three-cycle slots, sparse mask.
    exp3[0] = pk(1, 0, 0, 1, 0);
    exp3[1] = pk(1, 0, 0, 1, 0);
    exp3[2] = pk(1, 0, 0, 1, 0);
    exp3[3] = pk(1, 3, 1, 0, 0);
    exp3[4] = pk(1, 3, 1, 0, 0);
    exp3[5] = pk(1, 3, 1, 0, 0);
    exp3[6] = pk(0, 0, 0, 0, 1);
    exp3[7] = pk(0, 0, 0, 0, 1);
    en3 = 1'b1; i3 = 4'b1000; mask3 = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en3 = 1'b0; i3 = 4'b0111;
      check($sformatf("slot3_%0d", k), out3, exp3[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
